// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID pipeline register driven by hazard-unit stall/bubble requests and branch redirects.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module fetch_stall_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MAX_STALL = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCSTOP,
   input  logic        IDIF,
   input  logic        ControlMux,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] InstrIn,
   output logic [31:0] PC,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic        BubbleEX,
   output logic        Flushing,
   output logic        StallTimeout
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCycles
`endif
);

   typedef enum logic [1:0] {
      RUN,
      STALL,
      FLUSH
   } state_t;

   localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

   state_t      state;
   state_t      next_state;
   logic [31:0] pc_plus4;
   logic [7:0]  stall_run;

   assign pc_plus4 = PC + 32'd4;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Every state resolves the same way; a redirect always wins over a hold.
   always_comb begin
      next_state = state;
      case (state)
         RUN, STALL, FLUSH: begin
            if (BranchTaken) begin
               next_state = FLUSH;
            end else if (PCSTOP) begin
               next_state = STALL;
            end else begin
               next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   assign Flushing = (state == FLUSH);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         PC           <= RESET_PC;
         IFID_Instr   <= 32'd0;
         IFID_PCPlus4 <= 32'd0;
         IFID_Valid   <= 1'b0;
         BubbleEX     <= 1'b0;
      end else begin
         BubbleEX <= ControlMux | BranchTaken;
         if (BranchTaken) begin
            PC           <= BranchTarget & 32'hFFFF_FFFC;
            IFID_Instr   <= 32'd0;
            IFID_PCPlus4 <= 32'd0;
            IFID_Valid   <= 1'b0;
         end else begin
            if (!PCSTOP) begin
               PC <= pc_plus4;
            end
            if (!IDIF) begin
               IFID_Instr   <= InstrIn;
               IFID_PCPlus4 <= pc_plus4;
               IFID_Valid   <= 1'b1;
            end
         end
      end
   end

   // Timeout latches on the edge the run reaches the limit and survives until reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_run    <= 8'd0;
         StallTimeout <= 1'b0;
      end else if (BranchTaken || !PCSTOP) begin
         stall_run <= 8'd0;
      end else if (stall_run != MAX_STALL_C) begin
         stall_run <= stall_run + 8'd1;
         if (stall_run + 8'd1 == MAX_STALL_C) begin
            StallTimeout <= 1'b1;
         end
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         StallCycles <= 32'd0;
         FlushCycles <= 32'd0;
      end else begin
         if (PCSTOP && !BranchTaken && (StallCycles != 32'hFFFF_FFFF)) begin
            StallCycles <= StallCycles + 32'd1;
         end
         if (BranchTaken && (FlushCycles != 32'hFFFF_FFFF)) begin
            FlushCycles <= FlushCycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench for fetch_stall_ctrl: directed scenarios followed by random traffic
// checked against a behavioural model of the fetch stage.
module tb_fetch_stall_ctrl;

   localparam int MAX_STALL = 16;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        PCSTOP;
   logic        IDIF;
   logic        ControlMux;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] InstrIn;
   logic [31:0] PC;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic        BubbleEX;
   logic        Flushing;
   logic        StallTimeout;
`ifdef PERF_CNT_EN
   logic [31:0] StallCycles;
   logic [31:0] FlushCycles;
`endif

   int assert_count = 0;
   int fail_count   = 0;

   // Behavioural model state.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_bubble;
   logic        m_flushing;
   logic        m_timeout;
   int          m_run;
   longint      m_stall_cnt;
   longint      m_flush_cnt;

   fetch_stall_ctrl #(
      .RESET_PC (32'h0000_0000),
      .MAX_STALL(MAX_STALL)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .PCSTOP      (PCSTOP),
      .IDIF        (IDIF),
      .ControlMux  (ControlMux),
      .BranchTaken (BranchTaken),
      .BranchTarget(BranchTarget),
      .InstrIn     (InstrIn),
      .PC          (PC),
      .IFID_Instr  (IFID_Instr),
      .IFID_PCPlus4(IFID_PCPlus4),
      .IFID_Valid  (IFID_Valid),
      .BubbleEX    (BubbleEX),
      .Flushing    (Flushing),
      .StallTimeout(StallTimeout)
`ifdef PERF_CNT_EN
      ,
      .StallCycles (StallCycles),
      .FlushCycles (FlushCycles)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference behaviour: flushing means the previous edge redirected; the timeout
   // tracks an unbounded count of consecutive un-redirected PCSTOP edges.
   task automatic update_model();
      logic [31:0] old_pc;
      old_pc = m_pc;
      if (Reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_bubble = 1'b0; m_flushing = 1'b0; m_timeout = 1'b0; m_run = 0;
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         m_bubble   = ControlMux | BranchTaken;
         m_flushing = BranchTaken;
         if (BranchTaken) begin
            m_pc = {BranchTarget[31:2], 2'b00};
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_run = 0;
            if (m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
         end else begin
            if (!IDIF) begin
               m_instr = InstrIn;
               m_pc4   = 32'((64'(old_pc) + 64'd4) % 64'h1_0000_0000);
               m_valid = 1'b1;
            end
            if (!PCSTOP) begin
               m_pc  = 32'((64'(old_pc) + 64'd4) % 64'h1_0000_0000);
               m_run = 0;
            end else begin
               m_run++;
               if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            end
         end
         if (m_run >= MAX_STALL) m_timeout = 1'b1;
      end
   endtask

   task automatic check_output(input string tag);
      check_value({tag, "_pc"}, PC, m_pc);
      check_value({tag, "_instr"}, IFID_Instr, m_instr);
      check_value({tag, "_pc4"}, IFID_PCPlus4, m_pc4);
      check_value({tag, "_valid"}, 32'(IFID_Valid), 32'(m_valid));
      check_value({tag, "_bubble"}, 32'(BubbleEX), 32'(m_bubble));
      check_value({tag, "_flushing"}, 32'(Flushing), 32'(m_flushing));
      check_value({tag, "_timeout"}, 32'(StallTimeout), 32'(m_timeout));
`ifdef PERF_CNT_EN
      check_value({tag, "_stallcyc"}, StallCycles, 32'(m_stall_cnt));
      check_value({tag, "_flushcyc"}, FlushCycles, 32'(m_flush_cnt));
`endif
   endtask

   task automatic apply_stimulus(input string tag, input logic rst, input logic pcstop,
                                 input logic idif, input logic cmux, input logic bt,
                                 input logic [31:0] tgt, input logic [31:0] instr);
      Reset = rst; PCSTOP = pcstop; IDIF = idif; ControlMux = cmux;
      BranchTaken = bt; BranchTarget = tgt; InstrIn = instr;
      @(posedge Clk);
      update_model();
      #1;
      check_output(tag);
   endtask

   initial begin
      int burst;
      logic rs, ps, id, cm, bt;
      Reset = 1'b1; PCSTOP = 1'b0; IDIF = 1'b0; ControlMux = 1'b0;
      BranchTaken = 1'b0; BranchTarget = 32'h0; InstrIn = 32'h0;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_bubble = 1'b0;
      m_flushing = 1'b0; m_timeout = 1'b0; m_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;

      // Reset state
      apply_stimulus("rst", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      apply_stimulus("rst", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      check_value("rst_pc_const", PC, 32'h0);
      check_value("rst_valid_const", 32'(IFID_Valid), 32'h0);

      // Plain advance
      for (int i = 0; i < 3; i++) apply_stimulus("run", 0, 0, 0, 0, 0, 32'h0, 32'h2008_0005);
      check_value("run_pc_const", PC, 32'hC);
      check_value("run_instr_const", IFID_Instr, 32'h2008_0005);
      check_value("run_pc4_const", IFID_PCPlus4, 32'hC);

      // Full hold with bubble at PC=8
      apply_stimulus("rst2", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      apply_stimulus("adv", 0, 0, 0, 0, 0, 32'h0, 32'h1111_0000);
      apply_stimulus("adv", 0, 0, 0, 0, 0, 32'h0, 32'h2222_0000);
      for (int i = 0; i < 2; i++) apply_stimulus("hold", 0, 1, 1, 1, 0, 32'h0, 32'h3333_0000);
      check_value("hold_pc_const", PC, 32'h8);
      check_value("hold_instr_const", IFID_Instr, 32'h2222_0000);
      check_value("hold_bubble_const", 32'(BubbleEX), 32'h1);
      apply_stimulus("release", 0, 0, 0, 0, 0, 32'h0, 32'h3333_0000);
      check_value("release_pc_const", PC, 32'hC);
      check_value("release_bubble_const", 32'(BubbleEX), 32'h0);

      // Redirect overrides holds
      apply_stimulus("branch", 0, 1, 1, 0, 1, 32'h43, 32'h4444_0000);
      check_value("branch_pc_const", PC, 32'h40);
      check_value("branch_flush_const", 32'(Flushing), 32'h1);
      apply_stimulus("postbr", 0, 0, 0, 0, 0, 32'h0, 32'h5555_0000);
      check_value("postbr_flush_const", 32'(Flushing), 32'h0);

      // Stall timeout at the 16th edge
      for (int i = 1; i <= 20; i++) begin
         apply_stimulus("stall", 0, 1, 1, 0, 0, 32'h0, 32'h6666_0000);
         if (i == 15) check_value("timeout_early", 32'(StallTimeout), 32'h0);
         if (i == 16) check_value("timeout_rise", 32'(StallTimeout), 32'h1);
      end
      apply_stimulus("unstall", 0, 0, 0, 0, 0, 32'h0, 32'h7777_0000);
      check_value("timeout_sticky", 32'(StallTimeout), 32'h1);
      for (int i = 0; i < 9; i++) apply_stimulus("stall2", 0, 1, 0, 0, 0, 32'h0, 32'h0);
      apply_stimulus("stallrst", 1, 1, 0, 0, 0, 32'h0, 32'h0);
      check_value("timeout_cleared", 32'(StallTimeout), 32'h0);
      for (int i = 0; i < 10; i++) apply_stimulus("stall3", 0, 1, 0, 0, 0, 32'h0, 32'h0);
      check_value("timeout_none", 32'(StallTimeout), 32'h0);

      // PC wraparound
      apply_stimulus("wrapbr", 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0);
      apply_stimulus("wrap", 0, 0, 0, 0, 0, 32'h0, 32'h8888_0000);
      check_value("wrap_pc_const", PC, 32'h0);
      check_value("wrap_pc4_const", IFID_PCPlus4, 32'h0);

`ifdef PERF_CNT_EN
      apply_stimulus("perfrst", 1, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) apply_stimulus("perfstall", 0, 1, 0, 0, 0, 32'h0, 32'h0);
      apply_stimulus("perfbr", 0, 0, 0, 0, 1, 32'h100, 32'h0);
      apply_stimulus("perfbr", 0, 1, 0, 0, 1, 32'h200, 32'h0);
      check_value("perf_stall_const", StallCycles, 32'd5);
      check_value("perf_flush_const", FlushCycles, 32'd2);
`endif

      // Random traffic with occasional long PCSTOP bursts
      burst = 0;
      for (int i = 0; i < 600; i++) begin
         rs = ($urandom_range(0, 99) == 0);
         if (burst > 0) begin
            ps = 1'b1;
            burst--;
         end else begin
            ps = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) burst = $urandom_range(10, 24);
         end
         id = ($urandom_range(0, 2) == 0);
         cm = ($urandom_range(0, 3) == 0);
         bt = (burst == 0) && ($urandom_range(0, 9) == 0);
         apply_stimulus("rand", rs, ps, id, cm, bt, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
